// File: rtl/amplitude_detector_mc.sv
// Multi-channel amplitude detector for the IAGC datapath.
// Every channel sees the same window of N accepted samples. Each channel
// reports its unsigned peak, signed absolute peak or peak-to-peak value,
// and o_valid pulses for one cycle per completed window.

// Per-channel accumulator. It keeps all three statistics in parallel, so the
// clear value never depends on which mode is latched.
module amplitude_detector_mc_lane #(
  parameter int W = 16
) (
  input  logic         i_clock,
  input  logic         i_reset_n,
  input  logic         i_clear,
  input  logic         i_accept,
  input  logic [1:0]   i_mode,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_result
);
  localparam logic signed [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]        ONE  = W'(1);

  logic [W-1:0]        umax_q, umax_d;
  logic [W-1:0]        amax_q, amax_d;
  logic signed [W-1:0] smax_q, smax_d;
  logic signed [W-1:0] smin_q, smin_d;
  logic [W-1:0]        abs_x;
  logic signed [W-1:0] sx;

  // Next-value logic for the running max / |max| / signed max / signed min.
  always_comb begin
    sx     = $signed(i_data);
    // |-2^(W-1)| wraps to 2^(W-1), which is the correct unsigned magnitude.
    abs_x  = i_data[W-1] ? (~i_data + ONE) : i_data;
    umax_d = umax_q;
    amax_d = amax_q;
    smax_d = smax_q;
    smin_d = smin_q;
    if (i_clear) begin
      umax_d = '0;
      amax_d = '0;
      smax_d = SMIN;
      smin_d = SMAX;
    end else if (i_accept) begin
      if (i_data > umax_q) umax_d = i_data;
      if (abs_x  > amax_q) amax_d = abs_x;
      if (sx > smax_q)     smax_d = sx;
      if (sx < smin_q)     smin_d = sx;
    end
  end

  // Accumulator registers.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      umax_q <= '0;
      amax_q <= '0;
      smax_q <= SMIN;
      smin_q <= SMAX;
    end else begin
      umax_q <= umax_d;
      amax_q <= amax_d;
      smax_q <= smax_d;
      smin_q <= smin_d;
    end
  end

  // Select the result by window mode. The true max-min needs W+1 bits, but
  // after at least one sample it is non-negative and at most 2^W-1, so the
  // W-bit modular difference equals the truncated W+1-bit result exactly.
  always_comb begin
    case (i_mode)
      2'd1:    o_result = amax_q;
      2'd2:    o_result = smax_q - smin_q;
      default: o_result = umax_q;
    endcase
  end
endmodule

module amplitude_detector_mc #(
  parameter int NUM_CHANNELS         = 2,
  parameter int SAMPLER_DATA_SIZE    = 16,
  parameter int AMPLITUDE_COUNT_SIZE = 16,
  parameter int IAGC_STATUS_SIZE     = 4
) (
  input  logic                                      i_clock,
  input  logic                                      i_reset_n,
  input  logic                                      i_sample,
  input  logic [IAGC_STATUS_SIZE-1:0]               i_iagc_status,
  input  logic [1:0]                                i_mode,
  input  logic [AMPLITUDE_COUNT_SIZE-1:0]           i_amplitude_count,
  input  logic [NUM_CHANNELS*SAMPLER_DATA_SIZE-1:0] i_data,
  output logic [NUM_CHANNELS*SAMPLER_DATA_SIZE-1:0] o_amplitude,
  output logic                                      o_valid,
  output logic                                      o_busy
);
  localparam int W   = SAMPLER_DATA_SIZE;
  localparam int ACW = AMPLITUDE_COUNT_SIZE;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SAMPLE = 2'd1,
    S_DETECT = 2'd2
  } state_t;

  state_t                           state_q, state_d;
  logic [ACW-1:0]                   cnt_q, cnt_d;
  logic [ACW-1:0]                   n_q, n_d;
  logic [1:0]                       mode_q, mode_d;
  logic [NUM_CHANNELS-1:0][W-1:0]   amp_q, amp_d;
  logic                             valid_q, valid_d;
  logic                             busy_q, busy_d;
  logic                             clear, accept;
  logic [ACW-1:0]                   cnt_inc;
  logic [ACW-1:0]                   n_latch;
  logic                             status_on;
  logic [NUM_CHANNELS-1:0][W-1:0]   lane_data;
  logic [NUM_CHANNELS-1:0][W-1:0]   lane_res;

  assign lane_data = i_data;
  assign status_on = (i_iagc_status != '0);
  assign cnt_inc   = cnt_q + ACW'(1);
  // A window length of 0 would never close, so it is run as 1.
  assign n_latch   = (i_amplitude_count == '0) ? ACW'(1) : i_amplitude_count;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_lane
    amplitude_detector_mc_lane #(.W(W)) u_lane (
      .i_clock   (i_clock),
      .i_reset_n (i_reset_n),
      .i_clear   (clear),
      .i_accept  (accept),
      .i_mode    (mode_q),
      .i_data    (lane_data[c]),
      .o_result  (lane_res[c])
    );
  end

  // Window sequencing: IDLE waits for IAGC, SAMPLE counts strobes, and DETECT
  // publishes results during its single dead cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    mode_d  = mode_q;
    amp_d   = amp_q;
    valid_d = 1'b0;
    clear   = 1'b0;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        clear  = 1'b1;
        cnt_d  = '0;
        mode_d = i_mode;
        n_d    = n_latch;
        if (status_on) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (!status_on) begin
          state_d = S_IDLE;
        end else if (i_sample) begin
          accept = 1'b1;
          cnt_d  = cnt_inc;
          if (cnt_inc == n_q) state_d = S_DETECT;
        end
      end
      S_DETECT: begin
        clear  = 1'b1;
        cnt_d  = '0;
        mode_d = i_mode;
        n_d    = n_latch;
        if (status_on) begin
          amp_d   = lane_res;
          valid_d = 1'b1;
          state_d = S_SAMPLE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_SAMPLE) || (state_d == S_DETECT);
  end

  // Control and output registers.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      n_q     <= ACW'(1);
      mode_q  <= 2'd0;
      amp_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      mode_q  <= mode_d;
      amp_q   <= amp_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign o_amplitude = amp_q;
  assign o_valid     = valid_q;
  assign o_busy      = busy_q;
endmodule
